// File: rtl/f3m_mult_serial.sv
// rtl/f3m_mult_serial.sv - trit-serial GF(3^M) multiplier, reduction poly x^M + x^TAP + 2.
// Optional input trit check (err port) enabled by defining F3M_MULT_TRIT_CHECK_EN.
module f3m_mult_serial #(
  parameter int M   = 97,
  parameter int TAP = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*M-1:0] A,
  input  logic [2*M-1:0] B,
  output logic           busy,
  output logic           done,
`ifdef F3M_MULT_TRIT_CHECK_EN
  output logic           err,
`endif
  output logic [2*M-1:0] C
);

  localparam int CW = $clog2(M);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [2*M-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, c_q, c_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*M-1:0] step, shifted;
  logic [1:0]     t, bt, red;

  // GF(3) trit cells on the {hi,lo} encoding
  function automatic logic [1:0] tadd(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] tmul(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] p;
    case ({x, y})
      4'b0101, 4'b1010: p = 2'b01;
      4'b0110, 4'b1001: p = 2'b10;
      default:          p = 2'b00;
    endcase
    return p;
  endfunction

  // One row of M mult+add cells: acc*x reduced with x^M = 2x^TAP + 1, plus b*A
  always_comb begin
    t       = acc_q[2*M-1 -: 2];
    bt      = b_q[{cnt_q, 1'b0} +: 2];
    shifted = {acc_q[2*M-3:0], 2'b00};
    step    = '0;
    red     = 2'b00;
    for (int i = 0; i < M; i++) begin
      if (i == 0)        red = t;
      else if (i == TAP) red = tmul(2'b10, t);
      else               red = 2'b00;
      step[2*i +: 2] = tadd(tadd(shifted[2*i +: 2], red), tmul(bt, a_q[2*i +: 2]));
    end
  end

`ifdef F3M_MULT_TRIT_CHECK_EN
  logic flag_q, flag_d, illegal;

  always_comb begin
    illegal = 1'b0;
    for (int i = 0; i < M; i++) begin
      if ((&A[2*i +: 2]) || (&B[2*i +: 2])) illegal = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flag_q <= 1'b0;
    else       flag_q <= flag_d;
  end

  assign err = done & flag_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
`ifdef F3M_MULT_TRIT_CHECK_EN
    flag_d  = flag_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          cnt_d   = CW'(M - 1);
`ifdef F3M_MULT_TRIT_CHECK_EN
          flag_d  = illegal;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = step;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          c_d     = step;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign C    = c_q;

endmodule
